// File: rtl/uart_pixel_feeder_pkg.sv
// Shared state encodings for the pixel feeder's ingress (header insertion) and egress (UART handshake) FSMs.
package uart_pixel_feeder_pkg;

    typedef enum logic [1:0] {
        ING_IDLE = 2'd0,
        HDR0     = 2'd1,
        HDR1     = 2'd2
    } ing_state_t;

    typedef enum logic [1:0] {
        EG_IDLE = 2'd0,
        SEND    = 2'd1,
        GAP     = 2'd2
    } eg_state_t;

endpackage

// File: rtl/uart_pixel_feeder_byte_fifo.sv
// Byte FIFO with wrapping pointers and a separately tracked occupancy count.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_do_wr;
    logic                  w_do_rd;

    // full/empty are judged before this cycle's pop, so a write into a full FIFO is lost
    assign full    = (r_level == FULL_LVL);
    assign empty   = (r_level == '0);
    assign w_do_wr = wr_en & ~full;
    assign w_do_rd = rd_en & ~empty;
    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

    always_ff @(posedge CLK) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + (DEPTH_LOG2+1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_pixel_feeder.sv
// Buffers camera pixels, prefixes each frame with a 2-byte sync header, and drains
// bytes one at a time into uart_send over its DATA / DATA_READY / IDLE handshake.
module uart_pixel_feeder
    import uart_pixel_feeder_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] SYNC0      = 8'hA5,
    parameter logic [7:0] SYNC1      = 8'h5A
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  FRAME_START,
    input  logic                  PIX_VALID,
    input  logic [7:0]            PIX_DATA,
    input  logic                  OVF_CLR,
    input  logic                  TX_IDLE,
    output logic [7:0]            TX_DATA,
    output logic                  TX_READY,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  OVERFLOW
);

    localparam int                LVL_W    = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]  FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    ing_state_t         r_ing, w_ing_nxt;
    eg_state_t          r_eg, w_eg_nxt;
    logic [7:0]         r_tx_data;
    logic               r_ovf;
    logic               w_wr_en, w_rd_en, w_set_ovf, w_full, w_empty, w_room;
    logic [7:0]         w_wr_data, w_rd_data;
    logic [LVL_W-1:0]   w_level;

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_data),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    // A header is only started when both sync bytes are guaranteed to fit
    assign w_room = (w_level <= FULL_LVL - LVL_W'(2));

    always_comb begin
        w_ing_nxt = r_ing;
        w_wr_en   = 1'b0;
        w_wr_data = PIX_DATA;
        w_set_ovf = 1'b0;
        if (FRAME_START) begin
            w_set_ovf = PIX_VALID;
            if (w_room) begin
                w_ing_nxt = HDR0;
            end else begin
                w_ing_nxt = ING_IDLE;
                w_set_ovf = 1'b1;
            end
        end else begin
            case (r_ing)
                ING_IDLE: begin
                    if (PIX_VALID) begin
                        w_wr_en   = ~w_full;
                        w_set_ovf = w_full;
                    end
                end
                HDR0: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = SYNC0;
                    w_set_ovf = PIX_VALID;
                    w_ing_nxt = HDR1;
                end
                HDR1: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = SYNC1;
                    w_set_ovf = PIX_VALID;
                    w_ing_nxt = ING_IDLE;
                end
                default: w_ing_nxt = ING_IDLE;
            endcase
        end
    end

    // GAP covers the cycle uart_send still shows IDLE after sampling a byte
    always_comb begin
        w_eg_nxt = r_eg;
        w_rd_en  = 1'b0;
        case (r_eg)
            EG_IDLE: begin
                if (TX_IDLE && !w_empty) begin
                    w_rd_en  = 1'b1;
                    w_eg_nxt = SEND;
                end
            end
            SEND:    w_eg_nxt = GAP;
            GAP:     w_eg_nxt = EG_IDLE;
            default: w_eg_nxt = EG_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ing     <= ING_IDLE;
            r_eg      <= EG_IDLE;
            r_tx_data <= 8'h00;
            r_ovf     <= 1'b0;
        end else begin
            r_ing <= w_ing_nxt;
            r_eg  <= w_eg_nxt;
            if (w_rd_en) r_tx_data <= w_rd_data;
            if (w_set_ovf)    r_ovf <= 1'b1;
            else if (OVF_CLR) r_ovf <= 1'b0;
        end
    end

    assign TX_DATA  = r_tx_data;
    assign TX_READY = (r_eg == SEND);
    assign LEVEL    = w_level;
    assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_uart_pixel_feeder.sv
// Directed plus randomized checks of uart_pixel_feeder against a queue-based reference model.
module tb_uart_pixel_feeder;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       FRAME_START = 1'b0;
    logic       PIX_VALID = 1'b0;
    logic [7:0] PIX_DATA = 8'h00;
    logic       OVF_CLR = 1'b0;
    logic       TX_IDLE = 1'b0;
    logic [7:0] TX_DATA;
    logic       TX_READY;
    logic [4:0] LEVEL;
    logic       OVERFLOW;

    uart_pixel_feeder #(.DEPTH_LOG2(4), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .FRAME_START (FRAME_START),
        .PIX_VALID   (PIX_VALID),
        .PIX_DATA    (PIX_DATA),
        .OVF_CLR     (OVF_CLR),
        .TX_IDLE     (TX_IDLE),
        .TX_DATA     (TX_DATA),
        .TX_READY    (TX_READY),
        .LEVEL       (LEVEL),
        .OVERFLOW    (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;

    // Reference model: byte queue, remaining header bytes, cycles until the next pop may happen
    logic [7:0] q[$];
    int         cool;
    int         hdr_left;
    logic       m_ovf;
    logic       m_rdy;
    logic [7:0] m_data;
    logic       rel_pending = 1'b0;

    logic [7:0] tx_log[$];
    int         tx_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic model_reset();
        q.delete();
        cool     = 0;
        hdr_left = 0;
        m_ovf    = 1'b0;
        m_rdy    = 1'b0;
        m_data   = 8'h00;
    endtask

    task automatic cmp_all();
        chk("tx_ready", {31'd0, TX_READY}, {31'd0, m_rdy});
        chk("tx_data",  {24'd0, TX_DATA},  {24'd0, m_data});
        chk("level",    {27'd0, LEVEL},    q.size());
        chk("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
        if (TX_READY === 1'b1) begin
            tx_log.push_back(TX_DATA);
            tx_cyc.push_back(cyc_n);
        end
    endtask

    // One cycle: compare outputs, drive new inputs, advance the model across the coming edge
    task automatic step(input logic fs, input logic pv, input logic [7:0] pd,
                        input logic clr, input logic idle);
        int   lvl;
        logic full;
        logic set;
        @(negedge CLK);
        cyc_n++;
        cmp_all();
        if (rel_pending) begin
            RST_N = 1'b1;
            rel_pending = 1'b0;
        end
        FRAME_START = fs;
        PIX_VALID   = pv;
        PIX_DATA    = pd;
        OVF_CLR     = clr;
        TX_IDLE     = idle;
        lvl  = q.size();
        full = (lvl == 16);
        set  = 1'b0;
        if (cool == 0 && idle && lvl > 0) begin
            m_data = q.pop_front();
            m_rdy  = 1'b1;
            cool   = 2;
        end else begin
            m_rdy = 1'b0;
            if (cool > 0) cool--;
        end
        if (fs) begin
            if (pv) set = 1'b1;
            if (16 - lvl >= 2) hdr_left = 2;
            else begin
                hdr_left = 0;
                set = 1'b1;
            end
        end else if (hdr_left > 0) begin
            if (!full) q.push_back(hdr_left == 2 ? 8'hA5 : 8'h5A);
            hdr_left--;
            if (pv) set = 1'b1;
        end else if (pv) begin
            if (full) set = 1'b1;
            else q.push_back(pd);
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic idle_steps(input int n, input logic idle);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, idle);
    endtask

    initial begin
        logic [7:0] exp1 [3];
        logic [7:0] exp2 [3];
        int         guard;
        int         last_fs;
        exp1 = '{8'h10, 8'h11, 8'h12};
        exp2 = '{8'hA5, 8'h5A, 8'h33};
        model_reset();

        // reset state
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_ready", {31'd0, TX_READY}, 32'd0);
        chk("rst_data",  {24'd0, TX_DATA},  32'd0);
        chk("rst_level", {27'd0, LEVEL},    32'd0);
        chk("rst_ovf",   {31'd0, OVERFLOW}, 32'd0);
        rel_pending = 1'b1;

        // three pixels drained in order, 3 cycles apart
        tx_log.delete(); tx_cyc.delete();
        step(1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h12, 1'b0, 1'b1);
        idle_steps(12, 1'b1);
        chk("t1_count", tx_log.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < tx_log.size()) chk("t1_byte", {24'd0, tx_log[i]}, {24'd0, exp1[i]});
        if (tx_cyc.size() >= 3) begin
            chk("t1_gap0", tx_cyc[1] - tx_cyc[0], 32'd3);
            chk("t1_gap1", tx_cyc[2] - tx_cyc[1], 32'd3);
        end
        chk("t1_level", {27'd0, LEVEL}, 32'd0);

        // frame header then one pixel after blanking
        tx_log.delete(); tx_cyc.delete();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        idle_steps(2, 1'b1);
        step(1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
        idle_steps(14, 1'b1);
        chk("t2_count", tx_log.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < tx_log.size()) chk("t2_byte", {24'd0, tx_log[i]}, {24'd0, exp2[i]});
        chk("t2_ovf", {31'd0, OVERFLOW}, 32'd0);

        // fill past full with egress stalled, then clear overflow
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        idle_steps(1, 1'b0);
        chk("t3_level", {27'd0, LEVEL},    32'd16);
        chk("t3_ovf",   {31'd0, OVERFLOW}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle_steps(1, 1'b0);
        chk("t3_clr", {31'd0, OVERFLOW}, 32'd0);

        // write into full FIFO coincident with a pop is still a drop
        step(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
        idle_steps(1, 1'b0);
        chk("t5_level", {27'd0, LEVEL},    32'd15);
        chk("t5_ovf",   {31'd0, OVERFLOW}, 32'd1);

        // no room for a header at level 15
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle_steps(3, 1'b0);
        chk("t4_level", {27'd0, LEVEL},    32'd15);
        chk("t4_ovf",   {31'd0, OVERFLOW}, 32'd1);

        // drain to 5 and reset during a TX_READY pulse
        guard = 0;
        do begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            guard++;
        end while (!(q.size() == 5 && m_rdy) && guard < 200);
        chk("t6_reach", {31'd0, (guard < 200)}, 32'd1);
        @(posedge CLK);
        #2;
        chk("t6_pre_ready", {31'd0, TX_READY}, 32'd1);
        chk("t6_pre_level", {27'd0, LEVEL},    32'd5);
        RST_N = 1'b0;
        #1;
        chk("t6_rst_ready", {31'd0, TX_READY}, 32'd0);
        chk("t6_rst_level", {27'd0, LEVEL},    32'd0);
        model_reset();
        rel_pending = 1'b1;
        tx_log.delete(); tx_cyc.delete();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'hC7, 1'b0, 1'b1);
        idle_steps(8, 1'b1);
        chk("t6_count", tx_log.size(), 32'd1);
        if (tx_log.size() > 0) chk("t6_first", {24'd0, tx_log[0]}, 32'h0000_00C7);

        // randomized traffic; frame starts keep the guaranteed blanking gap
        last_fs = 0;
        for (int i = 0; i < 3000; i++) begin
            logic fs, pv, clr, idle;
            fs   = ($urandom_range(0, 59) == 0) && (i - last_fs > 3);
            if (fs) last_fs = i;
            pv   = ($urandom_range(0, 9) < 6);
            clr  = ($urandom_range(0, 39) == 0);
            idle = ($urandom_range(0, 9) < 3 + (i / 1000) * 2);
            step(fs, pv, 8'($urandom), clr, idle);
        end
        idle_steps(60, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
